// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
// State encoding, the minimum legal ratio and the ratio clamp.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int DIV_MIN = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// Period counter for the clock divider, with registered clko / clk_en.
// Flops are loaded with the values for the upcoming count, so they line up with r_cnt.
module clk_div_ctrl_cnt
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_n,
    input  logic             i_run,
    input  logic             i_load,
    output logic             o_last,
    output logic             o_clko,
    output logic             o_clk_en
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clko;
    logic             r_clk_en;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W:0]   w_half;

    // A reload always starts a period at 0, which is inside the high phase for any N >= 2,
    // so only the ratio currently in effect is needed here.
    always_comb begin
        w_cnt_inc  = r_cnt + 1'b1;
        w_half     = ({1'b0, i_n} + 1'b1) >> 1;
        w_cnt_next = (!i_run || i_load) ? '0 : w_cnt_inc;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_clko   <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_clko   <= i_run && ({1'b0, w_cnt_next} < w_half);
            r_clk_en <= i_run && (w_cnt_next == '0);
        end
    end

    assign o_last   = (r_cnt == i_n - 1'b1);
    assign o_clko   = r_clko;
    assign o_clk_en = r_clk_en;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller: ratio handshake, STOP/RUN/PEND sequencing.
// Optional sticky illegal-ratio flag o_err when CLK_DIV_CTRL_ERR_EN is defined.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_in,
    input  logic             i_div_valid,
    output logic             o_div_ready,
    output logic [DIV_W-1:0] o_div_cur,
    output logic             o_busy,
    output logic             o_clko,
`ifdef CLK_DIV_CTRL_ERR_EN
    output logic             o_clk_en,
    output logic             o_err
`else
    output logic             o_clk_en
`endif
);

    state_e           r_state;
    state_e           w_state_next;
    logic [DIV_W-1:0] r_div_cur;
    logic [DIV_W-1:0] w_div_cur_next;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_pend_next;
    logic [DIV_W-1:0] w_div_clamped;
    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic             w_last;

    assign w_accept      = i_div_valid && (r_state != PEND);
    assign w_div_clamped = DIV_W'(clamp_div(32'(i_div_in)));

    always_comb begin
        w_state_next   = r_state;
        w_div_cur_next = r_div_cur;
        w_pend_next    = r_pend_div;
        w_load         = 1'b0;
        case (r_state)
            STOP: begin
                if (w_accept) w_div_cur_next = w_div_clamped;
                if (i_en) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                // A ratio arriving in the last cycle is already on a boundary: apply it directly.
                if (w_last) begin
                    w_load       = 1'b1;
                    w_state_next = i_en ? RUN : STOP;
                    if (w_accept) w_div_cur_next = w_div_clamped;
                end else if (w_accept) begin
                    w_pend_next  = w_div_clamped;
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_last) begin
                    w_load         = 1'b1;
                    w_div_cur_next = r_pend_div;
                    w_state_next   = i_en ? RUN : STOP;
                end
            end
            default: w_state_next = STOP;
        endcase
        w_run = (w_state_next != STOP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= STOP;
            r_div_cur  <= DIV_W'(RESET_DIV);
            r_pend_div <= '0;
        end else begin
            r_state    <= w_state_next;
            r_div_cur  <= w_div_cur_next;
            r_pend_div <= w_pend_next;
        end
    end

    clk_div_ctrl_cnt #(
        .DIV_W(DIV_W)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_n     (r_div_cur),
        .i_run   (w_run),
        .i_load  (w_load),
        .o_last  (w_last),
        .o_clko  (o_clko),
        .o_clk_en(o_clk_en)
    );

`ifdef CLK_DIV_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (i_div_in < DIV_W'(DIV_MIN))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

    assign o_div_ready = (r_state != PEND);
    assign o_busy      = (r_state == PEND);
    assign o_div_cur   = r_div_cur;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_in;
    logic       div_valid;
    logic       div_ready;
    logic [7:0] div_cur;
    logic       busy;
    logic       clko;
    logic       clk_en;
`ifdef CLK_DIV_CTRL_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_W    (8),
        .RESET_DIV(4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_div_in   (div_in),
        .i_div_valid(div_valid),
        .o_div_ready(div_ready),
        .o_div_cur  (div_cur),
        .o_busy     (busy),
        .o_clko     (clko),
`ifdef CLK_DIV_CTRL_ERR_EN
        .o_clk_en   (clk_en),
        .o_err      (err)
`else
        .o_clk_en   (clk_en)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div_in = '0; div_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (clko !== 1'b0)       begin errors++; $display("FAIL reset_clko got %b exp 0", clko); end
        checks++; if (clk_en !== 1'b0)     begin errors++; $display("FAIL reset_clk_en got %b exp 0", clk_en); end
        checks++; if (div_cur !== 8'd4)    begin errors++; $display("FAIL reset_div_cur got %0d exp 4", div_cur); end
        checks++; if (div_ready !== 1'b1)  begin errors++; $display("FAIL reset_div_ready got %b exp 1", div_ready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
`ifdef CLK_DIV_CTRL_ERR_EN
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b exp 0", err); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_run();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (clko !== ((i % 4) < 2))     begin errors++; $display("FAIL run_clko i=%0d got %b exp %b", i, clko, (i % 4) < 2); end
            checks++; if (clk_en !== ((i % 4) == 0))  begin errors++; $display("FAIL run_clk_en i=%0d got %b exp %b", i, clk_en, (i % 4) == 0); end
            checks++; if (div_cur !== 8'd4)           begin errors++; $display("FAIL run_div_cur i=%0d got %0d exp 4", i, div_cur); end
            checks++; if (div_ready !== 1'b1)         begin errors++; $display("FAIL run_div_ready i=%0d got %b exp 1", i, div_ready); end
        end
        $display("test_run done");
    endtask

    task automatic test_ratio_change();
        @(negedge clk);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL chg_c0_clk_en got %b exp 1", clk_en); end
        @(negedge clk);
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL chg_c1_ready got %b exp 1", div_ready); end
        div_valid = 1'b1; div_in = 8'd3;
        @(negedge clk);
        div_valid = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL chg_c2_busy got %b exp 1", busy); end
        checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL chg_c2_ready got %b exp 0", div_ready); end
        checks++; if (div_cur !== 8'd4)   begin errors++; $display("FAIL chg_c2_div_cur got %0d exp 4", div_cur); end
        checks++; if (clko !== 1'b0)      begin errors++; $display("FAIL chg_c2_clko got %b exp 0", clko); end
        @(negedge clk);
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL chg_c3_busy got %b exp 1", busy); end
        checks++; if (div_cur !== 8'd4)   begin errors++; $display("FAIL chg_c3_div_cur got %0d exp 4", div_cur); end
        checks++; if (clk_en !== 1'b0)    begin errors++; $display("FAIL chg_c3_clk_en got %b exp 0", clk_en); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (clko !== ((i % 3) < 2))     begin errors++; $display("FAIL n3_clko i=%0d got %b exp %b", i, clko, (i % 3) < 2); end
            checks++; if (clk_en !== ((i % 3) == 0))  begin errors++; $display("FAIL n3_clk_en i=%0d got %b exp %b", i, clk_en, (i % 3) == 0); end
            checks++; if (div_cur !== 8'd3)           begin errors++; $display("FAIL n3_div_cur i=%0d got %0d exp 3", i, div_cur); end
            checks++; if (busy !== 1'b0)              begin errors++; $display("FAIL n3_busy i=%0d got %b exp 0", i, busy); end
        end
        $display("test_ratio_change done");
    endtask

    task automatic test_stop_restart();
        @(negedge clk);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL stop_c0_clk_en got %b exp 1", clk_en); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (clko !== 1'b1)   begin errors++; $display("FAIL stop_c1_clko got %b exp 1", clko); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL stop_c1_clk_en got %b exp 0", clk_en); end
        @(negedge clk);
        checks++; if (clko !== 1'b0)   begin errors++; $display("FAIL stop_c2_clko got %b exp 0", clko); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (clko !== 1'b0)   begin errors++; $display("FAIL stopped_clko i=%0d got %b exp 0", i, clko); end
            checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL stopped_clk_en i=%0d got %b exp 0", i, clk_en); end
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL restart_clk_en got %b exp 1", clk_en); end
        checks++; if (clko !== 1'b1)   begin errors++; $display("FAIL restart_clko got %b exp 1", clko); end
        @(negedge clk);
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL restart_c1_clk_en got %b exp 0", clk_en); end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (clko !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("FAIL restop clko/clk_en got %b/%b exp 0/0", clko, clk_en); end
        $display("test_stop_restart done");
    endtask

    task automatic test_clamp();
        en = 1'b1; div_valid = 1'b1; div_in = 8'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            div_valid = 1'b0;
            checks++; if (div_cur !== 8'd2)           begin errors++; $display("FAIL clamp_div_cur i=%0d got %0d exp 2", i, div_cur); end
            checks++; if (clko !== ((i % 2) == 0))    begin errors++; $display("FAIL clamp_clko i=%0d got %b exp %b", i, clko, (i % 2) == 0); end
            checks++; if (clk_en !== ((i % 2) == 0))  begin errors++; $display("FAIL clamp_clk_en i=%0d got %b exp %b", i, clk_en, (i % 2) == 0); end
        end
`ifdef CLK_DIV_CTRL_ERR_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clamp_err got %b exp 1", err); end
`endif
        $display("test_clamp done");
    endtask

    task automatic test_reset_pend();
        @(negedge clk);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rp_c0_clk_en got %b exp 1", clk_en); end
        div_valid = 1'b1; div_in = 8'd7;
        @(negedge clk);
        div_valid = 1'b0;
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL rp_busy got %b exp 1", busy); end
        checks++; if (div_cur !== 8'd2) begin errors++; $display("FAIL rp_div_cur got %0d exp 2", div_cur); end
        rst_n = 1'b0;
        #1;
        checks++; if (clko !== 1'b0)      begin errors++; $display("FAIL rp_rst_clko got %b exp 0", clko); end
        checks++; if (clk_en !== 1'b0)    begin errors++; $display("FAIL rp_rst_clk_en got %b exp 0", clk_en); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rp_rst_busy got %b exp 0", busy); end
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL rp_rst_ready got %b exp 1", div_ready); end
        checks++; if (div_cur !== 8'd4)   begin errors++; $display("FAIL rp_rst_div_cur got %0d exp 4", div_cur); end
`ifdef CLK_DIV_CTRL_ERR_EN
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rp_rst_err got %b exp 0", err); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (clko !== ((i % 4) < 2))     begin errors++; $display("FAIL rp_clko i=%0d got %b exp %b", i, clko, (i % 4) < 2); end
            checks++; if (clk_en !== ((i % 4) == 0))  begin errors++; $display("FAIL rp_clk_en i=%0d got %b exp %b", i, clk_en, (i % 4) == 0); end
            checks++; if (div_cur !== 8'd4)           begin errors++; $display("FAIL rp_div_cur i=%0d got %0d exp 4", i, div_cur); end
        end
        $display("test_reset_pend done");
    endtask

    task automatic test_stop_with_change();
        @(negedge clk);
        @(negedge clk);
        en = 1'b0; div_valid = 1'b1; div_in = 8'd6;
        @(negedge clk);
        div_valid = 1'b0;
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL swc_c2_busy got %b exp 1", busy); end
        checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL swc_c2_div_cur got %0d exp 4", div_cur); end
        @(negedge clk);
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL swc_c3_busy got %b exp 1", busy); end
        checks++; if (clko !== 1'b0)    begin errors++; $display("FAIL swc_c3_clko got %b exp 0", clko); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (div_cur !== 8'd6)   begin errors++; $display("FAIL swc_div_cur i=%0d got %0d exp 6", i, div_cur); end
            checks++; if (clko !== 1'b0)      begin errors++; $display("FAIL swc_clko i=%0d got %b exp 0", i, clko); end
            checks++; if (clk_en !== 1'b0)    begin errors++; $display("FAIL swc_clk_en i=%0d got %b exp 0", i, clk_en); end
            checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL swc_busy i=%0d got %b exp 0", i, busy); end
            checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL swc_ready i=%0d got %b exp 1", i, div_ready); end
        end
        $display("test_stop_with_change done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_ratio_change();
        test_stop_restart();
        test_clamp();
        test_reset_pend();
        test_stop_with_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
